// File: rtl/cond_flag_unit.sv
// ----------------------------------------------------------------------------
// cond_flag_unit
//
// Multi-lane ARM condition evaluator that owns the NZCV status register (SR)
// and a save/restore shadow stack used on exception entry and return.
// Every cycle, each lane's 4-bit condition field is evaluated against the
// flags and the pass/fail result is registered. Results appear one cycle
// after the query.
//
// Build option:
//   COND_FWD_EN  defined   : queries see the next-SR value, so an sr_we or
//                            pop in the same cycle is forwarded to them.
//                undefined : queries see the current SR register. A write
//                            becomes visible to queries one cycle later.
//
// Parameters:
//   LANES  number of condition query lanes (1..8)
//   DEPTH  shadow stack entries (power of two, 2..16)
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_rst        synchronous active-high reset
//   i_sr_we      load i_sr_in into SR
//   i_sr_in      new flags {N,Z,C,V}
//   i_push       save the current SR onto the shadow stack
//   i_pop        restore SR from the top of the shadow stack
//   i_q_valid    per-lane query valid
//   i_q_cond     per-lane condition field, lane i at [4i+3:4i]
//   o_check      registered pass(1)/fail(0) per lane
//   o_check_vld  registered copy of i_q_valid
//   o_sr_out     current SR
//   o_stk_cnt    shadow stack occupancy
//   o_stk_ovf    sticky: push attempted while full
//   o_stk_unf    sticky: pop attempted while empty
// ----------------------------------------------------------------------------
module cond_flag_unit #(
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sr_we,
  input  logic [3:0]               i_sr_in,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [LANES-1:0]         i_q_valid,
  input  logic [4*LANES-1:0]       i_q_cond,
  output logic [LANES-1:0]         o_check,
  output logic [LANES-1:0]         o_check_vld,
  output logic [3:0]               o_sr_out,
  output logic [$clog2(DEPTH):0]   o_stk_cnt,
  output logic                     o_stk_ovf,
  output logic                     o_stk_unf
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [3:0]       r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_unf;
  logic [LANES-1:0] r_check;
  logic [LANES-1:0] r_check_vld;
  logic [3:0]       r_stk [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_swap;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [IW-1:0]    w_top_idx;
  logic [IW-1:0]    w_wr_idx;
  logic [3:0]       w_top;
  logic [3:0]       w_sr_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [3:0]       w_q_flags;
  logic [LANES-1:0] w_check_nxt;

  // Full 16-way decode of the ARM condition field against {N,Z,C,V}.
  function automatic logic f_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic res;
    n   = f[3];
    z   = f[2];
    cf  = f[1];
    v   = f[0];
    res = 1'b0;
    case (c)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = cf;
      4'b0011: res = ~cf;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = cf & ~z;
      4'b1001: res = ~cf | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));

  // Push and pop together on a non-empty stack is a swap: the top entry is
  // exchanged with SR and occupancy is unchanged. Because a full stack is
  // never empty, a swap on a full stack is legal and does not overflow.
  // Push and pop on an empty stack degrades to a plain push with no
  // underflow.
  assign w_swap      = i_push & i_pop & ~w_empty;
  assign w_push_only = i_push & (~i_pop | w_empty) & ~w_full;
  assign w_pop_only  = i_pop & ~i_push & ~w_empty;
  assign w_ovf_evt   = i_push & ~i_pop & w_full;
  assign w_unf_evt   = i_pop & ~i_push & w_empty;

  // DEPTH is a power of two, so the low IW bits of the count minus one
  // address the top entry even when the stack is full (count == DEPTH).
  assign w_top_idx = r_cnt[IW-1:0] - IW'(1);
  assign w_wr_idx  = w_swap ? w_top_idx : r_cnt[IW-1:0];
  assign w_top     = r_stk[w_top_idx];

  always_comb begin
    w_sr_nxt = r_sr;
    if (i_pop && !w_empty) begin
      w_sr_nxt = w_top;
    end else if (i_sr_we) begin
      w_sr_nxt = i_sr_in;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push_only) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (w_pop_only) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

`ifdef COND_FWD_EN
  assign w_q_flags = w_sr_nxt;
`else
  assign w_q_flags = r_sr;
`endif

  always_comb begin
    w_check_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      w_check_nxt[i] = f_cond(i_q_cond[4*i +: 4], w_q_flags);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr        <= 4'b0000;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_check     <= '0;
      r_check_vld <= '0;
    end else begin
      r_sr        <= w_sr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_check     <= w_check_nxt;
      r_check_vld <= i_q_valid;
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end
      if (w_unf_evt) begin
        r_unf <= 1'b1;
      end
    end
  end

  // Stack storage is deliberately not reset; occupancy alone defines what
  // is readable, so clearing the entries would only cost reset fan-out.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (w_push_only || w_swap)) begin
      r_stk[w_wr_idx] <= r_sr;
    end
  end

  assign o_sr_out    = r_sr;
  assign o_stk_cnt   = r_cnt;
  assign o_stk_ovf   = r_ovf;
  assign o_stk_unf   = r_unf;
  assign o_check     = r_check;
  assign o_check_vld = r_check_vld;

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sr_we;
  logic [3:0]           sr_in;
  logic                 push;
  logic                 pop;
  logic [LANES-1:0]     q_valid;
  logic [4*LANES-1:0]   q_cond;
  logic [LANES-1:0]     check;
  logic [LANES-1:0]     check_vld;
  logic [3:0]           sr_out;
  logic [CW-1:0]        stk_cnt;
  logic                 stk_ovf;
  logic                 stk_unf;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [3:0]       m_sr;
  logic [3:0]       m_stk[$];
  logic             m_ovf;
  logic             m_unf;
  logic [LANES-1:0] exp_check;
  logic [LANES-1:0] exp_vld;

  cond_flag_unit #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sr_we     (sr_we),
    .i_sr_in     (sr_in),
    .i_push      (push),
    .i_pop       (pop),
    .i_q_valid   (q_valid),
    .i_q_cond    (q_cond),
    .o_check     (check),
    .o_check_vld (check_vld),
    .o_sr_out    (sr_out),
    .o_stk_cnt   (stk_cnt),
    .o_stk_ovf   (stk_ovf),
    .o_stk_unf   (stk_unf)
  );

  always #5 clk = ~clk;

  // Odd codes are the complement of the even code below them; 111x is
  // "always" and its complement.
  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  // Drive one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic apply(input logic r, input logic we, input logic [3:0] sin,
                       input logic pu, input logic po,
                       input logic [LANES-1:0] qv, input logic [4*LANES-1:0] qc);
    logic [3:0] old_sr, nsr, ev;
    int n;
    rst = r; sr_we = we; sr_in = sin; push = pu; pop = po;
    q_valid = qv; q_cond = qc;
    @(posedge clk);
    #1;
    if (r) begin
      m_sr = 4'b0000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      exp_check = '0; exp_vld = '0;
    end else begin
      old_sr = m_sr;
      n = m_stk.size();
      nsr = old_sr;
      if (po && n > 0) nsr = m_stk[n-1];
      else if (we) nsr = sin;
      if (pu && po && n > 0) m_stk[n-1] = old_sr;
      else if (pu && n < DEPTH) m_stk.push_back(old_sr);
      else if (pu) m_ovf = 1'b1;
      else if (po && n > 0) void'(m_stk.pop_back());
      else if (po) m_unf = 1'b1;
`ifdef COND_FWD_EN
      ev = nsr;
`else
      ev = old_sr;
`endif
      for (int i = 0; i < LANES; i++) exp_check[i] = m_cond(qc[4*i +: 4], ev);
      exp_vld = qv;
      m_sr = nsr;
    end
    rst = 1'b0; sr_we = 1'b0; push = 1'b0; pop = 1'b0; q_valid = '0;
  endtask

  task automatic test_reset;
    apply(1, 0, 4'h0, 0, 0, '0, '0);
    apply(1, 0, 4'h0, 0, 0, '0, '0);
    checks++; if (sr_out !== 4'b0000) begin errors++; $display("FAIL reset_sr got=%b exp=0000", sr_out); end
    checks++; if (stk_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stk_cnt); end
    checks++; if ({stk_ovf, stk_unf} !== 2'b00) begin errors++; $display("FAIL reset_sticky got=%b exp=00", {stk_ovf, stk_unf}); end
    checks++; if ({check, check_vld} !== 4'b0000) begin errors++; $display("FAIL reset_check got=%b exp=0000", {check, check_vld}); end
    apply(0, 0, 4'h0, 0, 0, 2'b11, {4'b1111, 4'b1110});
    checks++; if (check !== 2'b01) begin errors++; $display("FAIL al_nv_check got=%b exp=01", check); end
    checks++; if (check_vld !== 2'b11) begin errors++; $display("FAIL al_nv_vld got=%b exp=11", check_vld); end
    checks++; if (sr_out !== 4'b0000) begin errors++; $display("FAIL al_nv_sr got=%b exp=0000", sr_out); end
  endtask

  task automatic test_forward;
    apply(0, 1, 4'b0110, 0, 0, 2'b11, {4'b1001, 4'b1000});
    checks++; if (check !== exp_check) begin errors++; $display("FAIL fwd_same_cycle got=%b exp=%b", check, exp_check); end
    checks++; if (sr_out !== 4'b0110) begin errors++; $display("FAIL fwd_sr got=%b exp=0110", sr_out); end
    apply(0, 0, 4'h0, 0, 0, 2'b11, {4'b1001, 4'b1000});
    checks++; if (check !== 2'b10) begin errors++; $display("FAIL fwd_repeat got=%b exp=10", check); end
  endtask

  task automatic test_signed;
    logic [3:0] conds [4] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101};
    logic [3:0] exp_a = 4'b1010; // results for SR=1001, cond order above
    logic [3:0] exp_b = 4'b0101; // results for SR=1000
    apply(0, 1, 4'b1001, 0, 0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 4'h0, 0, 0, 2'b01, {4'b1110, conds[k]});
      checks++; if (check[0] !== exp_a[3-k] || check !== exp_check) begin errors++; $display("FAIL signed_nv k=%0d got=%b exp=%b", k, check[0], exp_a[3-k]); end
    end
    apply(0, 1, 4'b1000, 0, 0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 4'h0, 0, 0, 2'b01, {4'b1110, conds[k]});
      checks++; if (check[0] !== exp_b[3-k] || check !== exp_check) begin errors++; $display("FAIL signed_n k=%0d got=%b exp=%b", k, check[0], exp_b[3-k]); end
    end
  endtask

  task automatic test_stack;
    apply(1, 0, 4'h0, 0, 0, '0, '0);
    apply(0, 1, 4'b0001, 0, 0, '0, '0);
    for (int k = 0; k < 5; k++) apply(0, 0, 4'h0, 1, 0, '0, '0);
    checks++; if (stk_cnt !== CW'(4) || stk_ovf !== 1'b1) begin errors++; $display("FAIL push_full cnt=%0d ovf=%b exp cnt=4 ovf=1", stk_cnt, stk_ovf); end
    apply(0, 1, 4'b0100, 0, 0, '0, '0);
    apply(0, 0, 4'h0, 0, 1, '0, '0);
    checks++; if (sr_out !== 4'b0001 || stk_cnt !== CW'(3)) begin errors++; $display("FAIL pop_restore sr=%b cnt=%0d exp sr=0001 cnt=3", sr_out, stk_cnt); end
    // full stack swap is legal and must not overflow or change occupancy
    apply(0, 0, 4'h0, 1, 0, '0, '0);
    apply(0, 1, 4'b0111, 1, 1, '0, '0);
    checks++; if (sr_out !== m_sr || stk_cnt !== CW'(4)) begin errors++; $display("FAIL full_swap sr=%b cnt=%0d exp sr=%b cnt=4", sr_out, stk_cnt, m_sr); end

    apply(1, 0, 4'h0, 0, 0, '0, '0);
    apply(0, 1, 4'b1100, 0, 1, '0, '0);
    checks++; if (sr_out !== 4'b1100 || stk_unf !== 1'b1 || stk_cnt !== '0) begin errors++; $display("FAIL pop_empty sr=%b unf=%b cnt=%0d exp sr=1100 unf=1 cnt=0", sr_out, stk_unf, stk_cnt); end

    apply(1, 0, 4'h0, 0, 0, '0, '0);
    apply(0, 0, 4'h0, 1, 1, '0, '0);
    checks++; if (stk_cnt !== CW'(1) || stk_unf !== 1'b0) begin errors++; $display("FAIL pushpop_empty cnt=%0d unf=%b exp cnt=1 unf=0", stk_cnt, stk_unf); end

    apply(1, 0, 4'h0, 0, 0, '0, '0);
    apply(0, 1, 4'b0010, 0, 0, '0, '0);
    apply(0, 0, 4'h0, 1, 0, '0, '0);
    apply(0, 1, 4'b1000, 0, 0, '0, '0);
    apply(0, 0, 4'h0, 1, 1, '0, '0);
    checks++; if (sr_out !== 4'b0010 || stk_cnt !== CW'(1)) begin errors++; $display("FAIL swap sr=%b cnt=%0d exp sr=0010 cnt=1", sr_out, stk_cnt); end
    apply(0, 0, 4'h0, 0, 1, '0, '0);
    checks++; if (sr_out !== 4'b1000 || stk_cnt !== '0) begin errors++; $display("FAIL swap_top sr=%b cnt=%0d exp sr=1000 cnt=0", sr_out, stk_cnt); end

    apply(0, 1, 4'b1111, 1, 0, 2'b11, 8'hEE);
    apply(0, 0, 4'h0, 0, 1, '0, '0);
    apply(0, 0, 4'h0, 0, 1, '0, '0);
    apply(1, 1, 4'b0101, 1, 1, 2'b11, 8'hEE);
    checks++; if ({sr_out, stk_cnt, stk_ovf, stk_unf, check, check_vld} !== '0) begin errors++; $display("FAIL mid_reset sr=%b cnt=%0d ovf=%b unf=%b chk=%b vld=%b exp all 0", sr_out, stk_cnt, stk_ovf, stk_unf, check, check_vld); end
    apply(0, 0, 4'h0, 0, 1, '0, '0);
    checks++; if (stk_unf !== 1'b1 || stk_cnt !== '0) begin errors++; $display("FAIL post_reset_empty unf=%b cnt=%0d exp unf=1 cnt=0", stk_unf, stk_cnt); end
  endtask

  task automatic test_random;
    logic r, we, pu, po;
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 2) == 0);
      pu = ($urandom_range(0, 3) == 0);
      po = ($urandom_range(0, 3) == 0);
      apply(r, we, 4'($urandom), pu, po, LANES'($urandom), (4*LANES)'($urandom));
      checks++;
      if (check !== exp_check || check_vld !== exp_vld || sr_out !== m_sr ||
          stk_cnt !== CW'(m_stk.size()) || stk_ovf !== m_ovf || stk_unf !== m_unf) begin
        errors++;
        $display("FAIL random k=%0d got chk=%b vld=%b sr=%b cnt=%0d ovf=%b unf=%b exp chk=%b vld=%b sr=%b cnt=%0d ovf=%b unf=%b",
                 k, check, check_vld, sr_out, stk_cnt, stk_ovf, stk_unf,
                 exp_check, exp_vld, m_sr, m_stk.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sr_we = 1'b0; sr_in = '0; push = 1'b0; pop = 1'b0;
    q_valid = '0; q_cond = '0;
    m_sr = '0; m_ovf = 1'b0; m_unf = 1'b0; exp_check = '0; exp_vld = '0;
    test_reset();
    test_forward();
    test_signed();
    test_stack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
